// File: rtl/fb_vport_timing.sv
// fb_vport_timing: raster timing generator plus RGB555 stream-to-port adapter.
// The raster counters free-run from reset, so the sink always sees a stable mode.
// The stream is locked to the raster on a start-of-frame pixel (ALIGN -> RUN).
// Optional build macro FB_VPORT_TESTPATTERN_EN adds iPATTERN. When iPATTERN is
// high, active pixels show 8 colour bars and the stream is ignored.
module fb_vport_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        iCLK,
  input  logic        iRESET,
`ifdef FB_VPORT_TESTPATTERN_EN
  input  logic        iPATTERN,
`endif
  input  logic        iFB_START,
  input  logic [14:0] iFB_RGB,
  input  logic        iFB_DV,
  output logic        oFB_READY,
  output logic [7:0]  oRED,
  output logic [7:0]  oGRN,
  output logic [7:0]  oBLU,
  output logic        oHS,
  output logic        oVS,
  output logic        oDE,
  output logic        oLOCKED,
  output logic        oUNDERRUN
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  // Counter-width constants, so every compare is width-matched.
  localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST_C  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST_C  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {ALIGN, RUN} state_t;

  state_t        state, nextState;
  logic [HW-1:0] hCnt;
  logic [VW-1:0] vCnt;
  logic          hLast, vLast, origin, pixActive, hSync, vSync;
  logic          showPix, starve, misStart;
  logic [7:0]    pixR, pixG, pixB;

  // 5-bit to 8-bit colour: replicate the top bits into the new LSBs
  // so that full scale maps to full scale.
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  assign hLast     = (hCnt == H_LAST_C);
  assign vLast     = (vCnt == V_LAST_C);
  assign origin    = (hCnt == '0) && (vCnt == '0);
  assign pixActive = (hCnt < H_ACT_C) && (vCnt < V_ACT_C);
  assign hSync     = (hCnt >= HS_FIRST) && (hCnt <= HS_LAST);
  assign vSync     = (vCnt >= VS_FIRST) && (vCnt <= VS_LAST);
  assign oLOCKED   = (state == RUN);

`ifdef FB_VPORT_TESTPATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [HW-1:0] BAR_C = HW'(BAR_W);
  logic [2:0] barIdx;
  // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  assign barIdx = 3'(hCnt / BAR_C);
`endif

  // Free-running raster counters; they never depend on stream state.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (hLast) begin
      hCnt <= '0;
      vCnt <= vLast ? '0 : vCnt + 1'b1;
    end else begin
      hCnt <= hCnt + 1'b1;
    end
  end

  // Lock state register.
  always_ff @(posedge iCLK) begin
    if (iRESET) state <= ALIGN;
    else        state <= nextState;
  end

  // Next state, ready handshake, and pixel selection for this position.
  always_comb begin
    nextState = state;
    oFB_READY = 1'b0;
    showPix   = 1'b0;
    starve    = 1'b0;
    misStart  = iFB_START && !origin;
    case (state)
      ALIGN: begin
        // Discard pixels until a start pixel appears. Hold the start pixel
        // until the frame wrap, so it is consumed at (0,0).
        oFB_READY = iFB_DV && !iFB_START;
        if (hLast && vLast && iFB_DV && iFB_START) nextState = RUN;
      end
      RUN: begin
        oFB_READY = pixActive && !misStart;
        if (pixActive) begin
          if (!iFB_DV) begin
            starve = 1'b1;
          end else if (misStart) begin
            nextState = ALIGN;
          end else begin
            showPix = 1'b1;
            if (origin && !iFB_START) nextState = ALIGN;
          end
        end
      end
      default: nextState = ALIGN;
    endcase
`ifdef FB_VPORT_TESTPATTERN_EN
    if (iPATTERN) begin
      nextState = ALIGN;
      oFB_READY = 1'b0;
      showPix   = 1'b0;
      starve    = 1'b0;
    end
`endif
  end

  // Colour of the pixel for this cycle (black unless a pixel is shown).
  always_comb begin
    pixR = 8'h00;
    pixG = 8'h00;
    pixB = 8'h00;
    if (showPix) begin
      pixR = expand5(iFB_RGB[14:10]);
      pixG = expand5(iFB_RGB[9:5]);
      pixB = expand5(iFB_RGB[4:0]);
    end
`ifdef FB_VPORT_TESTPATTERN_EN
    if (iPATTERN && pixActive) begin
      pixR = {8{~barIdx[1]}};
      pixG = {8{~barIdx[2]}};
      pixB = {8{~barIdx[0]}};
    end
`endif
  end

  // Output register: everything reflects the previous cycle's position.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      oRED      <= 8'h00;
      oGRN      <= 8'h00;
      oBLU      <= 8'h00;
      oDE       <= 1'b0;
      oHS       <= ~HS_POL;
      oVS       <= ~VS_POL;
      oUNDERRUN <= 1'b0;
    end else begin
      oRED      <= pixR;
      oGRN      <= pixG;
      oBLU      <= pixB;
      oDE       <= pixActive;
      oHS       <= hSync ? HS_POL : ~HS_POL;
      oVS       <= vSync ? VS_POL : ~VS_POL;
      oUNDERRUN <= oUNDERRUN | starve;
    end
  end

endmodule

// File: tb/tb_fb_vport_timing.sv
// Directed bench for fb_vport_timing using a small mode:
// H 8/1/2/1 (12 cycles per line), V 4/1/1/1 (7 lines), 84 cycles per frame.
module tb_fb_vport_timing;
  localparam int HT = 12;
  localparam int VT = 7;

  typedef struct {
    int          p;
    logic [14:0] rgb;
    logic [23:0] expRgb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, fbStart, fbDv, fbReady;
  logic [14:0] fbRgb;
  logic [7:0]  red, grn, blu;
  logic        hs, vs, de, locked, underrun;

  always #5 clk = ~clk;

  fb_vport_timing #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .iCLK(clk), .iRESET(rst),
    .iFB_START(fbStart), .iFB_RGB(fbRgb), .iFB_DV(fbDv),
    .oFB_READY(fbReady),
    .oRED(red), .oGRN(grn), .oBLU(blu),
    .oHS(hs), .oVS(vs), .oDE(de),
    .oLOCKED(locked), .oUNDERRUN(underrun)
  );

  int          nVec = 0, nBad = 0;
  int          cyc = 0, idx = 0, accCnt = 0;
  int          dropCyc = -1, misCyc = -1, rstCyc = -1;
  bit          srcEn = 1'b0;
  logic [14:0] pixMem [32];
  vec_t        vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One pixel clock. The source presents pixMem[idx] with start on idx 0
  // and advances on acceptance. It also checks raster timing for the
  // position just completed.
  task automatic tick();
    int h, v;
    bit acc, wasRst, expDe;
    h = cyc % HT;
    v = (cyc / HT) % VT;
    wasRst = (cyc == rstCyc);
    rst = wasRst;
    if (cyc == misCyc) idx = 0;
    fbDv    = srcEn && (cyc != dropCyc);
    fbStart = srcEn && (idx == 0);
    fbRgb   = srcEn ? pixMem[idx] : 15'h0;
    @(negedge clk);
    acc = fbDv && fbReady && !wasRst;
    if (cyc == misCyc) check("misplaced start ready", 32'(fbReady), 32'd0);
    @(posedge clk);
    #1;
    if (acc) begin
      idx = (idx + 1) % 32;
      accCnt++;
    end else if (cyc == dropCyc) begin
      idx = (idx + 1) % 32;
    end
    if (wasRst) begin
      rst = 1'b0;
      rstCyc = -1;
      cyc = 0;
      idx = 0;
    end else begin
      expDe = (h < 8) && (v < 4);
      check("de timing", 32'(de), 32'(expDe));
      check("hs timing", 32'(hs), 32'(!(h >= 9 && h <= 10)));
      check("vs timing", 32'(vs), 32'(v != 5));
      if (!expDe) check("blank rgb", {8'h0, red, grn, blu}, 32'h0);
      cyc++;
    end
  endtask

  initial begin
    int deCnt, hsLow, vsLow, rgbNz, lockCnt, wc, target;
    vecs[0] = '{p: 0,  rgb: 15'h7C00, expRgb: 24'hFF0000};
    vecs[1] = '{p: 3,  rgb: 15'h0200, expRgb: 24'h008400};
    vecs[2] = '{p: 9,  rgb: 15'h001F, expRgb: 24'h0000FF};
    vecs[3] = '{p: 14, rgb: 15'h4210, expRgb: 24'h848484};
    vecs[4] = '{p: 20, rgb: 15'h0400, expRgb: 24'h080000};
    vecs[5] = '{p: 27, rgb: 15'h01E0, expRgb: 24'h007B00};
    vecs[6] = '{p: 31, rgb: 15'h0000, expRgb: 24'h000000};

    // Reset values
    rst = 1'b1; fbDv = 1'b0; fbStart = 1'b0; fbRgb = 15'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset de", 32'(de), 32'd0);
    check("reset hs", 32'(hs), 32'd1);
    check("reset vs", 32'(vs), 32'd1);
    check("reset rgb", {8'h0, red, grn, blu}, 32'h0);
    check("reset locked", 32'(locked), 32'd0);
    check("reset underrun", 32'(underrun), 32'd0);
    check("reset ready", 32'(fbReady), 32'd0);
    rst = 1'b0;
    cyc = 0;

    // Frame 0: free-running raster with no stream
    deCnt = 0; hsLow = 0; vsLow = 0; rgbNz = 0; lockCnt = 0;
    repeat (84) begin
      tick();
      deCnt += int'(de);
      hsLow += int'(!hs);
      vsLow += int'(!vs);
      rgbNz += int'({red, grn, blu} != 24'h0);
      lockCnt += int'(locked);
    end
    check("idle de count", 32'(deCnt), 32'd32);
    check("idle hs low count", 32'(hsLow), 32'd14);
    check("idle vs low count", 32'(vsLow), 32'd12);
    check("idle rgb nonzero", 32'(rgbNz), 32'd0);
    check("idle locked", 32'(lockCnt), 32'd0);

    // Frame 1: white stream aligns; lock on the edge ending cycle 167
    for (int i = 0; i < 32; i++) pixMem[i] = 15'h7FFF;
    srcEn = 1'b1;
    while (cyc < 167) tick();
    check("locked before wrap", 32'(locked), 32'd0);
    tick();
    check("locked at wrap", 32'(locked), 32'd1);

    // Frame 2: 32 white pixels accepted and shown
    accCnt = 0; wc = 0;
    while (cyc < 252) begin
      tick();
      wc += int'(de && {red, grn, blu} == 24'hFFFFFF);
    end
    check("frame2 accepted", 32'(accCnt), 32'd32);
    check("frame2 white pixels", 32'(wc), 32'd32);
    check("frame2 underrun", 32'(underrun), 32'd0);
    check("frame2 locked", 32'(locked), 32'd1);

    // Frame 3: colour expansion vectors at chosen positions
    for (int i = 0; i < 32; i++) pixMem[i] = 15'h7FFF;
    foreach (vecs[k]) pixMem[vecs[k].p] = vecs[k].rgb;
    foreach (vecs[k]) begin
      target = 252 + (vecs[k].p / 8) * HT + (vecs[k].p % 8);
      while (cyc <= target) tick();
      check($sformatf("colour vec %0d", k), {8'h0, red, grn, blu}, {8'h0, vecs[k].expRgb});
      check($sformatf("colour vec %0d de", k), 32'(de), 32'd1);
    end
    while (cyc < 336) tick();

    // Frame 4: pixel 3 of line 1 starved; the source drops it
    for (int i = 0; i < 32; i++) pixMem[i] = {5'(i + 1), 5'(31 - i), 5'(i)};
    accCnt = 0;
    dropCyc = 336 + HT + 3;
    while (cyc <= dropCyc) tick();
    check("starved pixel black", {8'h0, red, grn, blu}, 32'h0);
    check("starved pixel de", 32'(de), 32'd1);
    check("underrun set", 32'(underrun), 32'd1);
    tick();
    check("pixel 4 after starve", {8'h0, red, grn, blu}, 32'h006B9C63);
    check("locked after starve", 32'(locked), 32'd1);
    while (cyc < 420) tick();
    check("frame4 accepted", 32'(accCnt), 32'd31);
    check("underrun sticky", 32'(underrun), 32'd1);
    check("frame4 locked", 32'(locked), 32'd1);

    // Frame 5: misplaced start at pixel 5 of line 2, relock at wrap
    misCyc = 420 + 2 * HT + 5;
    while (cyc <= misCyc) tick();
    check("misplaced pixel black", {8'h0, red, grn, blu}, 32'h0);
    check("misplaced unlock", 32'(locked), 32'd0);
    tick();
    check("align pixel black", {8'h0, red, grn, blu}, 32'h0);
    while (cyc < 503) tick();
    check("still aligning", 32'(locked), 32'd0);
    tick();
    check("relocked", 32'(locked), 32'd1);
    tick();
    check("relock first pixel", {8'h0, red, grn, blu}, 32'h0008FF00);
    check("underrun held", 32'(underrun), 32'd1);

    // Frame 6: one-cycle reset mid-line while in RUN
    rstCyc = 504 + HT + 3;
    while (cyc < rstCyc) tick();
    tick();
    check("midreset de", 32'(de), 32'd0);
    check("midreset hs", 32'(hs), 32'd1);
    check("midreset vs", 32'(vs), 32'd1);
    check("midreset rgb", {8'h0, red, grn, blu}, 32'h0);
    check("midreset locked", 32'(locked), 32'd0);
    check("midreset underrun", 32'(underrun), 32'd0);
    tick();
    check("restart de at h0", 32'(de), 32'd1);
    check("restart rgb black", {8'h0, red, grn, blu}, 32'h0);
    check("restart locked", 32'(locked), 32'd0);
    while (cyc <= 8) tick();
    check("restart de off at h8", 32'(de), 32'd0);
    while (cyc < 84) tick();
    check("relock after reset", 32'(locked), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
